// File: rtl/matrix_row_loader.sv
// Word-serial row loader: assembles vecSize rows of regSize bits into a
// matrix and holds it for the transpose stage under valid/ready.
module matrix_row_loader #(
  parameter int regSize = 32,
  parameter int vecSize = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic                             in_valid,
  input  logic [regSize-1:0]               in_data,
  output logic                             in_ready,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [vecSize-1:0][regSize-1:0]  matrix_out,
  output logic [$clog2(vecSize):0]         fill_count
);

  localparam int CW = $clog2(vecSize) + 1;

  typedef enum logic {FILL, FULL} state_e;

  state_e                          state_q, state_d;
  logic [vecSize-1:0][regSize-1:0] rows_q, rows_d;
  logic [CW-1:0]                   fill_q, fill_d;
  logic                            valid_q, valid_d;
  logic                            accept;
  logic                            xfer;

  // FULL only lets a word in when the held matrix leaves the same cycle
  assign in_ready   = (state_q == FILL) | out_ready;
  assign accept     = in_valid & in_ready;
  assign xfer       = valid_q & out_ready;
  assign out_valid  = valid_q;
  assign matrix_out = rows_q;
  assign fill_count = fill_q;

  always_comb begin
    state_d = state_q;
    rows_d  = rows_q;
    fill_d  = fill_q;
    valid_d = valid_q;
    if (clear) begin
      state_d = FILL;
      rows_d  = '0;
      fill_d  = '0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FILL: begin
          if (accept) begin
            for (int k = 0; k < vecSize; k++) begin
              if (fill_q == CW'(k)) rows_d[k] = in_data;
            end
            fill_d = fill_q + CW'(1);
            if (fill_q == CW'(vecSize - 1)) begin
              state_d = FULL;
              valid_d = 1'b1;
            end
          end
        end
        FULL: begin
          if (xfer) begin
            state_d = FILL;
            valid_d = 1'b0;
            if (accept) begin
              rows_d[0] = in_data;
              fill_d    = CW'(1);
            end else begin
              fill_d    = '0;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      rows_q  <= '0;
      fill_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rows_q  <= rows_d;
      fill_q  <= fill_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_matrix_row_loader.sv
// Bench for matrix_row_loader: table vectors, directed corner sequences
// and random traffic against a queue-level reference model.
module tb_matrix_row_loader;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear;
  logic             in_valid;
  logic [31:0]      in_data;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [3:0][31:0] matrix_out;
  logic [2:0]       fill_count;

  matrix_row_loader #(.regSize(32), .vecSize(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .matrix_out (matrix_out),
    .fill_count (fill_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // reference: the list of rows held, plus whether a whole matrix waits
  logic [31:0] m_rows [4];
  int          m_cnt;
  bit          m_full;

  typedef struct {
    bit        clr;
    bit        iv;
    logic [31:0] d;
    bit        ordy;
    bit        ev;
    bit        er;
    int        ef;
  } vec_t;

  vec_t tv [$];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit c, input bit v, input logic [31:0] d,
                       input bit r);
    clear     = c;
    in_valid  = v;
    in_data   = d;
    out_ready = r;
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) m_rows[k] = '0;
    m_cnt  = 0;
    m_full = 0;
  endtask

  task automatic m_update();
    if (clear) begin
      m_reset();
    end else if (m_full) begin
      if (out_ready) begin
        m_full = 0;
        if (in_valid) begin
          m_rows[0] = in_data;
          m_cnt     = 1;
        end else begin
          m_cnt = 0;
        end
      end
    end else if (in_valid) begin
      m_rows[m_cnt] = in_data;
      m_cnt++;
      m_full = (m_cnt == 4);
    end
  endtask

  task automatic cmp_model();
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("in_ready", 32'(in_ready), 32'(!m_full || out_ready));
    chk("fill_count", 32'(fill_count), 32'(m_cnt));
    for (int k = 0; k < 4; k++) chk($sformatf("row%0d", k), matrix_out[k], m_rows[k]);
  endtask

  task automatic adv();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic step();
    #4;
    cmp_model();
    adv();
  endtask

  logic [31:0] fill_words [4];
  logic [31:0] exp_t [4];
  logic [31:0] tr;
  int          nx;

  initial begin
    fill_words = '{32'h7b5b5465, 32'h73745665, 32'h63746f72, 32'h5d53475d};
    exp_t      = '{32'h7b73635d, 32'h5b747453, 32'h54566f47, 32'h6565725d};

    rst = 1'b1;
    drive(0, 0, '0, 0);
    m_reset();
    #12;
    rst = 1'b0;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_fill", 32'(fill_count), 32'd0);
    chk("rst_matrix", 32'(|matrix_out), 32'd0);
    @(posedge clk);
    #1;

    // basic fill, then backpressure, then single release
    for (int i = 0; i < 4; i++)
      tv.push_back('{0, 1, fill_words[i], 0, 0, 1, i});
    tv.push_back('{0, 0, 32'h0, 0, 1, 0, 4});
    for (int i = 0; i < 10; i++)
      tv.push_back('{0, 1, 32'hdeadbeef, 0, 1, 0, 4});
    tv.push_back('{0, 1, 32'hdeadbeef, 1, 1, 1, 4});
    tv.push_back('{0, 0, 32'h0, 0, 0, 1, 1});

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].clr, tv[i].iv, tv[i].d, tv[i].ordy);
      #4;
      chk($sformatf("tv%0d_valid", i), 32'(out_valid), 32'(tv[i].ev));
      chk($sformatf("tv%0d_ready", i), 32'(in_ready), 32'(tv[i].er));
      chk($sformatf("tv%0d_fill", i), 32'(fill_count), 32'(tv[i].ef));
      if (i >= 4 && i <= 15) begin
        for (int k = 0; k < 4; k++)
          chk($sformatf("held_row%0d", k), matrix_out[k], fill_words[k]);
      end
      if (i == 4) begin
        for (int j = 0; j < 4; j++) begin
          for (int k = 0; k < 4; k++)
            tr[8*(3-k) +: 8] = matrix_out[k][8*(3-j) +: 8];
          chk($sformatf("transpose%0d", j), tr, exp_t[j]);
        end
      end
      cmp_model();
      adv();
    end
    chk("bp_row0", matrix_out[0], 32'hdeadbeef);

    // clear after a partial fill
    drive(0, 1, 32'h11111111, 0); step();
    drive(1, 0, 32'h0, 0); step();
    #4;
    chk("clr_fill", 32'(fill_count), 32'd0);
    chk("clr_matrix", 32'(|matrix_out), 32'd0);
    chk("clr_valid", 32'(out_valid), 32'd0);
    cmp_model();
    adv();

    // streaming with out_ready held high
    nx = 0;
    for (int c = 1; c <= 13; c++) begin
      drive(0, c <= 12, 32'(c), 1);
      #4;
      chk("stream_ready", 32'(in_ready), 32'd1);
      if (out_valid && out_ready) begin
        chk("stream_cycle", 32'(c), 32'(5 + 4 * nx));
        for (int k = 0; k < 4; k++)
          chk("stream_row", matrix_out[k], 32'(4 * nx + k + 1));
        nx++;
      end
      cmp_model();
      adv();
    end
    chk("stream_xfers", 32'(nx), 32'd3);

    // gapped input
    for (int c = 1; c <= 9; c++) begin
      drive(0, (c % 2 == 1) && c <= 7, $urandom, 0);
      #4;
      if (c == 7) chk("gap_valid_early", 32'(out_valid), 32'd0);
      if (c == 8) chk("gap_valid", 32'(out_valid), 32'd1);
      cmp_model();
      adv();
    end

    // clear while full beats a simultaneous transfer and accept
    drive(1, 1, 32'hcafef00d, 1); step();
    #4;
    chk("clrfull_row0", matrix_out[0], 32'h0);
    chk("clrfull_valid", 32'(out_valid), 32'd0);
    chk("clrfull_fill", 32'(fill_count), 32'd0);
    adv();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive($urandom_range(15) == 0, $urandom_range(3) != 0, $urandom,
            $urandom_range(2) != 0);
      step();
    end

    // async reset while full
    drive(1, 0, 32'h0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, $urandom, 0); step();
    end
    drive(0, 0, 32'h0, 0);
    #1;
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_matrix", 32'(|matrix_out), 32'd0);
    chk("arst_fill", 32'(fill_count), 32'd0);
    #1;
    rst = 1'b0;
    m_reset();
    cmp_model();
    adv();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 32'ha0 + 32'(i), 0); step();
    end
    drive(0, 0, 32'h0, 0);
    #4;
    chk("refill_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 4; k++)
      chk("refill_row", matrix_out[k], 32'ha0 + 32'(k));
    cmp_model();
    adv();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/matrix_row_loader.md
Name: matrix_row_loader

Overview:
- Word-serial input stage that builds a vecSize x regSize matrix, one row per accepted word.
- Presents the completed matrix, held stable, to the downstream matrix_transpose stage, with a valid/ready handshake on both sides.
- Sits between the vector register-file/memory read path and the transpose unit of the SIMD datapath.
- Back-to-back matrices stream without bubbles.

Parameters:
- regSize, 32, width of one row/word in bits.
- vecSize, 4, rows per matrix (words per load); must be ≥2.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- clear  input  1  synchronous abort; discards the partial or full matrix.
- in_valid  input  1  in_data holds a valid row word.
- in_data  input  regSize  next row word.
- in_ready  output  1  loader accepts in_data this cycle.
- out_valid  output  1  matrix_out holds a complete matrix.
- out_ready  input  1  downstream consumes matrix_out this cycle.
- matrix_out  output  [regSize-1:0] x [vecSize-1:0]  assembled matrix; row k is the k-th accepted word; drives matrix_in of the transpose stage.
- fill_count  output  $clog2(vecSize)+1  rows currently held (0..vecSize).

Behaviour:
- Reset (async, rst=1): all matrix_out rows = 0, out_valid = 0, fill_count = 0, state = FILL, in_ready = 1.
- Handshakes:
  - Input accept = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
  - Both are evaluated at the rising edge.
- State machine:
  - FILL: out_valid = 0; in_ready = 1. On accept, write in_data to row[fill_count] and increment fill_count. When the accept brings fill_count to vecSize, go to FULL.
  - FULL: out_valid = 1; matrix_out is held constant; in_ready = out_ready (combinational).
    - Transfer with no accept: fill_count -> 0, go to FILL.
    - Transfer with a simultaneous accept: in_data is written to row[0], fill_count -> 1, go to FILL. If vecSize rows are never written this way, the remaining rows keep their stale values until overwritten.
    - No transfer: remain in FULL; in_data is ignored.
- Latency:
  - out_valid rises the cycle after the vecSize-th accept.
  - Sustained throughput is one matrix per vecSize cycles, with no bubble between matrices.
- Row ordering:
  - Rows are written strictly in order 0..vecSize-1.
  - No byte swapping; bit i of in_data goes to bit i of the row.
- Output rules:
  - out_valid, once high, stays high until a transfer occurs. It never drops on its own.
  - matrix_out is stable while out_valid = 1.
- clear (synchronous, priority over all handshakes):
  - Next state FILL, fill_count = 0, out_valid = 0, all rows zeroed.
  - An accept or transfer in the same cycle is discarded, as if it never happened.
- Reset mid-fill or while FULL: the partial/full matrix is lost immediately and outputs take their reset values.
- in_valid low during FILL: hold state; gaps between words are allowed.
- fill_count never exceeds vecSize. No overflow path exists, because in_ready = 0 in FULL without out_ready.

Test Plan:
- Basic fill:
  - Stimulus: after reset, in_valid = 1 for 4 cycles with 7b5b5465, 73745665, 63746f72, 5d53475d; out_ready = 0.
  - Required: out_valid = 1 on cycle 5; matrix_out[0..3] = 7b5b5465, 73745665, 63746f72, 5d53475d; fill_count = 4; in_ready = 0.
  - Downstream transpose then yields rows 7b73635d, 5b747453, 54566f47, 6565725d.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles with in_valid = 1, in_data = deadbeef.
  - Required: matrix_out unchanged, out_valid = 1, no row written. Then out_ready = 1 for 1 cycle -> out_valid = 0 next cycle, fill_count = 1, row0 = deadbeef.
- Streaming:
  - Stimulus: out_ready = 1 constantly; 12 consecutive words 00000001..0000000c.
  - Required: exactly 3 transfers, on cycles 5, 9 and 13. Matrices are {1,2,3,4}, {5,6,7,8}, {9,a,b,c}. in_ready is never low.
- Gapped input:
  - Stimulus: in_valid toggles 1,0,1,0,...
  - Required: fill_count increments only on accept cycles; out_valid asserts the cycle after the 4th accept.
- Clear:
  - Stimulus: clear after 2 words.
  - Required: next cycle fill_count = 0, rows = 0, out_valid = 0. Clear while FULL with out_ready = 1 and in_valid = 1 -> no transfer counted, row0 = 0.
- Async reset:
  - Stimulus: assert rst mid-cycle while FULL.
  - Required: out_valid = 0 and matrix_out = 0 immediately, without waiting for a clock edge. After release, a fresh 4-word fill works normally.
